// File: rtl/rtc_disp_pkg.sv
// Shared constants for the RTC display register bank: register map, status bits, blink phase.
// Consumed by rtc_display_regs and rtc_blink_timer (the latter built only with RTC_BLINK_EN).
package rtc_disp_pkg;

  localparam logic [3:0] ADDR_SEC    = 4'd0;
  localparam logic [3:0] ADDR_MIN    = 4'd1;
  localparam logic [3:0] ADDR_HOUR   = 4'd2;
  localparam logic [3:0] ADDR_DAY    = 4'd3;
  localparam logic [3:0] ADDR_MONTH  = 4'd4;
  localparam logic [3:0] ADDR_YEAR   = 4'd5;
  localparam logic [3:0] ADDR_CSEC   = 4'd6;
  localparam logic [3:0] ADDR_CMIN   = 4'd7;
  localparam logic [3:0] ADDR_CHOUR  = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;

  localparam int unsigned ST_IRQ      = 0;
  localparam int unsigned ST_MODE12   = 1;
  localparam int unsigned HOUR_PM_BIT = 7;

  localparam logic [3:0] EDIT_NONE = 4'hF;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } blink_phase_e;

  function automatic logic bcd_nibble_bad(input logic [3:0] n);
    return n > 4'd9;
  endfunction

endpackage

// File: rtl/rtc_blink_timer.sv
// Edit-field blink timer: counts frame ticks and toggles the blank phase every BLINK_FRAMES.
// Instantiated by rtc_display_regs only when RTC_BLINK_EN is defined.
module rtc_blink_timer
  import rtc_disp_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned NFIELDS      = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [3:0]         edit_field,
  output logic [NFIELDS-1:0] blank_mask
);

  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  blink_phase_e  phase_q, phase_d;
  logic [3:0]    edit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= PHASE_ON;
      edit_q  <= EDIT_NONE;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      edit_q  <= edit_field;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (edit_field != edit_q) begin
      cnt_d   = '0;
      phase_d = PHASE_ON;
    end else if (frame_tick) begin
      if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Gated on an unchanged edit_field so a field switch un-blanks in the same cycle.
  always_comb begin
    blank_mask = '0;
    if (phase_q == PHASE_OFF && edit_field == edit_q && 32'(edit_field) < NFIELDS) begin
      blank_mask[edit_field] = 1'b1;
    end
  end

endmodule

// File: rtl/rtc_display_regs.sv
// Frame-synchronous RTC shadow/display register bank feeding the text overlay.
// Define RTC_BLINK_EN to build the edit-field blink timer; otherwise blank_mask is tied low.
module rtc_display_regs
  import rtc_disp_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned NFIELDS      = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [3:0]         wr_addr,
  input  logic [7:0]         wr_data,
  input  logic               frame_tick,
  input  logic [3:0]         edit_field,
  output logic [3:0]         digUS,
  output logic [3:0]         digDS,
  output logic [3:0]         digUM,
  output logic [3:0]         digDM,
  output logic [3:0]         digUH,
  output logic [3:0]         digDH,
  output logic [3:0]         digUD,
  output logic [3:0]         digDD,
  output logic [3:0]         digUME,
  output logic [3:0]         digDME,
  output logic [3:0]         digUA,
  output logic [3:0]         digDA,
  output logic [3:0]         digUSC,
  output logic [3:0]         digDSC,
  output logic [3:0]         digUMC,
  output logic [3:0]         digDMC,
  output logic [3:0]         digUHC,
  output logic [3:0]         digDHC,
  output logic               am_ind,
  output logic               pm_ind,
  output logic               alarm_ind,
  output logic               bad_bcd,
  output logic [NFIELDS-1:0] blank_mask
);

  logic [7:0] shadow_q [NFIELDS];
  logic [7:0] shadow_d [NFIELDS];
  logic [7:0] disp_q   [NFIELDS];
  logic [7:0] disp_d   [NFIELDS];
  logic [1:0] sstat_q, sstat_d;
  logic [1:0] dstat_q, dstat_d;
  logic       dirty_q, dirty_d;
  logic       bad_q, bad_d;

  logic       field_wr, status_wr;
  logic       units_bad, tens_bad;
  logic [3:0] tens_chk;
  logic [7:0] wr_clean;

  assign field_wr  = wr_en && (32'(wr_addr) < NFIELDS);
  assign status_wr = wr_en && (wr_addr == ADDR_STATUS);

  // Hour tens excludes the PM bit, so it can never be out of range and bit7 survives intact.
  assign tens_chk  = (wr_addr == ADDR_HOUR) ? {1'b0, wr_data[6:4]} : wr_data[7:4];
  assign units_bad = bcd_nibble_bad(wr_data[3:0]);
  assign tens_bad  = bcd_nibble_bad(tens_chk);
  assign wr_clean  = {tens_bad ? 4'h0 : wr_data[7:4], units_bad ? 4'h0 : wr_data[3:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '{default: '0};
      disp_q   <= '{default: '0};
      sstat_q  <= '0;
      dstat_q  <= '0;
      dirty_q  <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      sstat_q  <= sstat_d;
      dstat_q  <= dstat_d;
      dirty_q  <= dirty_d;
      bad_q    <= bad_d;
    end
  end

  // Commit reads the registered shadow, so a same-cycle write stays pending with dirty set.
  always_comb begin
    shadow_d = shadow_q;
    disp_d   = disp_q;
    sstat_d  = sstat_q;
    dstat_d  = dstat_q;
    dirty_d  = dirty_q;
    bad_d    = bad_q;
    if (frame_tick && dirty_q) begin
      disp_d  = shadow_q;
      dstat_d = sstat_q;
      dirty_d = 1'b0;
    end
    if (field_wr) begin
      shadow_d[wr_addr] = wr_clean;
      dirty_d           = 1'b1;
      if (units_bad || tens_bad) begin
        bad_d = 1'b1;
      end
    end
    if (status_wr) begin
      sstat_d = wr_data[1:0];
      dirty_d = 1'b1;
    end
  end

  assign digUS  = disp_q[ADDR_SEC][3:0];
  assign digDS  = disp_q[ADDR_SEC][7:4];
  assign digUM  = disp_q[ADDR_MIN][3:0];
  assign digDM  = disp_q[ADDR_MIN][7:4];
  assign digUH  = disp_q[ADDR_HOUR][3:0];
  assign digDH  = {2'b00, disp_q[ADDR_HOUR][5:4]};
  assign digUD  = disp_q[ADDR_DAY][3:0];
  assign digDD  = disp_q[ADDR_DAY][7:4];
  assign digUME = disp_q[ADDR_MONTH][3:0];
  assign digDME = disp_q[ADDR_MONTH][7:4];
  assign digUA  = disp_q[ADDR_YEAR][3:0];
  assign digDA  = disp_q[ADDR_YEAR][7:4];
  assign digUSC = disp_q[ADDR_CSEC][3:0];
  assign digDSC = disp_q[ADDR_CSEC][7:4];
  assign digUMC = disp_q[ADDR_CMIN][3:0];
  assign digDMC = disp_q[ADDR_CMIN][7:4];
  assign digUHC = disp_q[ADDR_CHOUR][3:0];
  assign digDHC = disp_q[ADDR_CHOUR][7:4];

  assign am_ind    = dstat_q[ST_MODE12] & ~disp_q[ADDR_HOUR][HOUR_PM_BIT];
  assign pm_ind    = dstat_q[ST_MODE12] &  disp_q[ADDR_HOUR][HOUR_PM_BIT];
  assign alarm_ind = dstat_q[ST_IRQ];
  assign bad_bcd   = bad_q;

  logic unused_hour_b6;
  assign unused_hour_b6 = disp_q[ADDR_HOUR][6];

`ifdef RTC_BLINK_EN
  rtc_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES),
    .NFIELDS     (NFIELDS)
  ) u_blink (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .edit_field(edit_field),
    .blank_mask(blank_mask)
  );
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^{edit_field, BLINK_FRAMES[0]};
  assign blank_mask       = '0;
`endif

endmodule

// File: tb/tb_rtc_display_regs.sv
// Scoreboard bench for rtc_display_regs; the blink sequence runs when RTC_BLINK_EN is defined.
`timescale 1ns/1ps
module tb_rtc_display_regs;
  import rtc_disp_pkg::*;

  logic       clk = 1'b0;
  logic       reset, wr_en, frame_tick;
  logic [3:0] wr_addr, edit_field;
  logic [7:0] wr_data;
  logic [3:0] digUS, digDS, digUM, digDM, digUH, digDH, digUD, digDD, digUME, digDME;
  logic [3:0] digUA, digDA, digUSC, digDSC, digUMC, digDMC, digUHC, digDHC;
  logic       am_ind, pm_ind, alarm_ind, bad_bcd;
  logic [8:0] blank_mask;

  always #5 clk = ~clk;

  rtc_display_regs #(
    .BLINK_FRAMES(2),
    .NFIELDS     (9)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_tick(frame_tick), .edit_field(edit_field),
    .digUS(digUS), .digDS(digDS), .digUM(digUM), .digDM(digDM), .digUH(digUH), .digDH(digDH),
    .digUD(digUD), .digDD(digDD), .digUME(digUME), .digDME(digDME), .digUA(digUA), .digDA(digDA),
    .digUSC(digUSC), .digDSC(digDSC), .digUMC(digUMC), .digDMC(digDMC),
    .digUHC(digUHC), .digDHC(digDHC),
    .am_ind(am_ind), .pm_ind(pm_ind), .alarm_ind(alarm_ind), .bad_bcd(bad_bcd),
    .blank_mask(blank_mask)
  );

  // Digit word reads as the BCD bytes chour..sec, high to low.
  logic [71:0] digs_act;
  logic [3:0]  flags_act;
  assign digs_act  = {digDHC, digUHC, digDMC, digUMC, digDSC, digUSC, digDA, digUA,
                      digDME, digUME, digDD, digUD, digDH, digUH, digDM, digUM, digDS, digUS};
  assign flags_act = {am_ind, pm_ind, alarm_ind, bad_bcd};

  typedef struct {
    string       name;
    int unsigned at;
    logic [71:0] digs;
    logic [3:0]  flags;
    logic [8:0]  mask;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      mon_e = sbq.pop_front();
      n_vec++;
      if (mon_e.at != cyc || digs_act !== mon_e.digs || flags_act !== mon_e.flags ||
          blank_mask !== mon_e.mask) begin
        n_err++;
        $display("FAIL %s: got digs=%h amPmAlBad=%b mask=%h, want digs=%h amPmAlBad=%b mask=%h (cycle %0d, due %0d)",
                 mon_e.name, digs_act, flags_act, blank_mask,
                 mon_e.digs, mon_e.flags, mon_e.mask, cyc, mon_e.at);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic expect_now(input string n, input logic [71:0] dg, input logic [3:0] fl,
                            input logic [8:0] mk);
    exp_t e;
    e.name = n; e.at = cyc; e.digs = dg; e.flags = fl; e.mask = mk;
    sbq.push_back(e);
  endtask

  localparam logic [71:0] D_FULL = 72'h235859071015113045;

  initial begin
    reset = 1'b1; wr_en = 1'b0; frame_tick = 1'b0;
    wr_addr = '0; wr_data = '0; edit_field = EDIT_NONE;
    repeat (3) step();
    reset = 1'b0;
    step();
    expect_now("reset_state", 72'h0, 4'b0000, 9'h0);

    wr(ADDR_SEC, 8'h45);
    expect_now("sec_no_tick", 72'h0, 4'b0000, 9'h0);
    tick();
    expect_now("sec_commit", 72'h45, 4'b0000, 9'h0);

    wr(ADDR_HOUR, 8'h91); wr(ADDR_STATUS, 8'h02); tick();
    expect_now("hour_pm_12h", 72'h110045, 4'b0100, 9'h0);
    wr(ADDR_STATUS, 8'h00); tick();
    expect_now("mode24_no_pm", 72'h110045, 4'b0000, 9'h0);
    wr(ADDR_HOUR, 8'hD2); wr(ADDR_STATUS, 8'h03); tick();
    expect_now("hour_bit6_alarm", 72'h120045, 4'b0110, 9'h0);
    wr(ADDR_HOUR, 8'h11); wr(ADDR_STATUS, 8'h02); tick();
    expect_now("hour_am", 72'h110045, 4'b1000, 9'h0);

    wr(ADDR_DAY, 8'h15);
    wr_en = 1'b1; wr_addr = ADDR_MIN; wr_data = 8'h30; frame_tick = 1'b1;
    step();
    wr_en = 1'b0; frame_tick = 1'b0;
    expect_now("simul_wr_tick", 72'h15110045, 4'b1000, 9'h0);
    tick();
    expect_now("simul_next_tick", 72'h15113045, 4'b1000, 9'h0);
    tick();
    expect_now("clean_tick", 72'h15113045, 4'b1000, 9'h0);

    wr(ADDR_MONTH, 8'h1A);
    expect_now("bad_bcd_set", 72'h15113045, 4'b1001, 9'h0);
    tick();
    expect_now("bad_units_zeroed", 72'h1015113045, 4'b1001, 9'h0);
    wr(ADDR_YEAR, 8'hA7); wr(ADDR_CSEC, 8'h59); wr(ADDR_CMIN, 8'h58); wr(ADDR_CHOUR, 8'h23);
    tick();
    expect_now("bad_tens_chrono", D_FULL, 4'b1001, 9'h0);
    wr(4'd12, 8'h77); wr(4'd15, 8'hFF);
    expect_now("ignored_addr", D_FULL, 4'b1001, 9'h0);
    tick();
    expect_now("ignored_no_commit", D_FULL, 4'b1001, 9'h0);

`ifdef RTC_BLINK_EN
    edit_field = 4'd1;
    step();
    expect_now("blink_start", D_FULL, 4'b1001, 9'h0);
    tick(); expect_now("blink_t1", D_FULL, 4'b1001, 9'h000);
    tick(); expect_now("blink_t2", D_FULL, 4'b1001, 9'h002);
    tick(); expect_now("blink_t3", D_FULL, 4'b1001, 9'h002);
    tick(); expect_now("blink_t4", D_FULL, 4'b1001, 9'h000);
    tick(); expect_now("blink_t5", D_FULL, 4'b1001, 9'h000);
    tick(); expect_now("blink_t6", D_FULL, 4'b1001, 9'h002);
    edit_field = 4'd3;
    expect_now("blink_edit_change", D_FULL, 4'b1001, 9'h000);
    step();
    tick(); expect_now("blink_restart", D_FULL, 4'b1001, 9'h000);
    edit_field = EDIT_NONE;
    step();
`else
    edit_field = 4'd1;
    step();
    repeat (3) begin
      tick();
      expect_now("mask_tied_low", D_FULL, 4'b1001, 9'h0);
    end
    edit_field = EDIT_NONE;
    step();
`endif

    wr(ADDR_SEC, 8'h12);
    reset = 1'b1;
    expect_now("async_reset", 72'h0, 4'b0000, 9'h0);
    step();
    reset = 1'b0;
    tick();
    expect_now("post_reset_tick", 72'h0, 4'b0000, 9'h0);
    wr(ADDR_MIN, 8'h07); tick();
    expect_now("post_reset_commit", 72'h0700, 4'b0000, 9'h0);

    for (int i = 0; i < 8 && sbq.size() > 0; i++) step();
    if (sbq.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
      n_err += sbq.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
